// File: rtl/ble_session_controller.sv
// ble_session_controller
//   Top-level BLE session FSM: deep sleep (IDLE), module programming with a
//   queued error-report path to the UART, AT-command setup, advertisement and
//   connected phases. Failed setup/advertise attempts are counted; when the
//   count reaches MAX_RETRIES the block parks in LOCKOUT until reprogrammed.
//
//   Optional feature macro: BLE_SESSION_BACKOFF_EN
//     defined   : tmr_count = slp_time_count << retry_cnt, saturating at all-ones
//     undefined : tmr_count = slp_time_count
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     slp_time_count           base sleep duration, captured on IDLE entry
//     programming, direct_conn level requests evaluated in IDLE/LOCKOUT
//     setup_done, fail         setup engine result pulses
//     connect, disconnect,
//     time_out                 connection monitor pulses
//     error_pulse, error_code  error strobe + code (queued in PROGRAMMING/ERROR_ACK)
//     tx_full                  UART TX backpressure
//     tmr_done                 sleep timer expiry
//     tmr_enable/clear/count   sleep timer control
//     en_cmd_mem_wr, setting_up, mux_tx_setup, mux_transceiver, mux_rx_setup
//                              phase controls (Moore decode of state)
//     tx_valid, tx_data        UART TX write strobe and zero-extended error code
//     retry_cnt, locked_out, err_overflow  status
module ble_session_controller #(
  parameter int ERR_CODE_W     = 2,
  parameter int TX_DATA_W      = 8,
  parameter int ERR_FIFO_DEPTH = 4,
  parameter int MAX_RETRIES    = 3,
  parameter int SLP_W          = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLP_W-1:0]      slp_time_count,
  input  logic                  programming,
  input  logic                  direct_conn,
  input  logic                  setup_done,
  input  logic                  fail,
  input  logic                  connect,
  input  logic                  disconnect,
  input  logic                  time_out,
  input  logic                  error_pulse,
  input  logic [ERR_CODE_W-1:0] error_code,
  input  logic                  tx_full,
  input  logic                  tmr_done,
  output logic                  tmr_enable,
  output logic                  tmr_clear,
  output logic [SLP_W-1:0]      tmr_count,
  output logic                  en_cmd_mem_wr,
  output logic                  setting_up,
  output logic                  mux_tx_setup,
  output logic                  mux_transceiver,
  output logic [1:0]            mux_rx_setup,
  output logic                  tx_valid,
  output logic [TX_DATA_W-1:0]  tx_data,
  output logic [3:0]            retry_cnt,
  output logic                  locked_out,
  output logic                  err_overflow
);

  localparam int PTR_W = $clog2(ERR_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PROG, S_ERR_ACK, S_SETUP, S_ADV, S_CONN, S_LOCKOUT
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       retry_nxt;
  logic             retry_last;
  logic             idle_entry;
  logic             clr_q;
  logic [SLP_W-1:0] tmr_load;

  // error queue
  logic [ERR_CODE_W-1:0] mem [ERR_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      q_cnt;
  logic                  q_empty, q_full, push_ok, q_wr, pop;

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == CNT_W'(ERR_FIFO_DEPTH));
  assign push_ok = error_pulse && (state == S_PROG || state == S_ERR_ACK);
  assign pop     = tx_valid;
  // a push into a full queue still lands when the head leaves on the same edge
  assign q_wr    = push_ok && (!q_full || pop);

  assign retry_last = ({1'b0, retry_cnt} + 5'd1) == 5'(MAX_RETRIES);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      S_IDLE: begin
        if (programming)      state_nxt = S_PROG;
        else if (direct_conn) state_nxt = S_CONN;
        else if (tmr_done)    state_nxt = S_SETUP;
      end
      S_PROG: begin
        if (!q_empty)         state_nxt = S_ERR_ACK;
        else if (!programming) state_nxt = S_IDLE;
      end
      S_ERR_ACK: begin
        if (q_empty) state_nxt = S_PROG;
      end
      S_SETUP: begin
        // fail outranks a coincident setup_done
        if (fail) begin
          if (retry_last) state_nxt = S_LOCKOUT;
          else begin
            state_nxt = S_IDLE;
            retry_nxt = retry_cnt + 4'd1;
          end
        end else if (setup_done) begin
          state_nxt = S_ADV;
        end
      end
      S_ADV: begin
        if (connect) begin
          state_nxt = S_CONN;
          retry_nxt = '0;
        end else if (time_out) begin
          if (retry_last) state_nxt = S_LOCKOUT;
          else begin
            state_nxt = S_IDLE;
            retry_nxt = retry_cnt + 4'd1;
          end
        end
      end
      S_CONN: begin
        if (disconnect) begin
          state_nxt = S_IDLE;
          retry_nxt = '0;
        end
      end
      S_LOCKOUT: begin
        if (programming) begin
          state_nxt = S_PROG;
          retry_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: Moore outputs ----------------
  always_comb begin
    tmr_enable      = 1'b0;
    en_cmd_mem_wr   = 1'b0;
    setting_up      = 1'b0;
    mux_tx_setup    = 1'b0;
    mux_transceiver = 1'b0;
    mux_rx_setup    = 2'b00;
    tx_valid        = 1'b0;
    locked_out      = 1'b0;
    case (state)
      S_IDLE:    tmr_enable = 1'b1;
      S_PROG: begin
        en_cmd_mem_wr = 1'b1;
        mux_rx_setup  = 2'b01;
        mux_tx_setup  = 1'b1;
      end
      S_ERR_ACK: begin
        mux_rx_setup = 2'b01;
        mux_tx_setup = 1'b1;
        tx_valid     = !q_empty && !tx_full;
      end
      S_SETUP:   setting_up      = 1'b1;
      S_ADV:     mux_rx_setup    = 2'b10;
      S_CONN:    mux_transceiver = 1'b1;
      S_LOCKOUT: locked_out      = 1'b1;
      default: ;
    endcase
  end

  assign tx_data = tx_valid ? TX_DATA_W'(mem[rd_ptr]) : '0;

  // ---------------- sleep timer load value ----------------
`ifdef BLE_SESSION_BACKOFF_EN
  // retry_cnt is at most 15, so 15 guard bits catch every overflow
  logic [SLP_W+14:0] shifted;
  assign shifted  = {15'd0, slp_time_count} << retry_cnt;
  assign tmr_load = (|shifted[SLP_W+14:SLP_W]) ? '1 : shifted[SLP_W-1:0];
`else
  assign tmr_load = slp_time_count;
`endif

  assign idle_entry = (state_nxt == S_IDLE) && (state != S_IDLE);

  // clr_q comes out of reset set so the first post-reset cycle sees a clear;
  // gating with rst keeps tmr_clear low while reset is still held.
  assign tmr_clear = clr_q && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q        <= 1'b1;
      tmr_count    <= '0;
      err_overflow <= 1'b0;
    end else begin
      clr_q <= idle_entry;
      // retry_cnt here is the pre-increment value, so the first backoff is x1
      if (idle_entry) tmr_count <= tmr_load;
      if (state_nxt == S_PROG && (state == S_IDLE || state == S_LOCKOUT))
        err_overflow <= 1'b0;
      else if (push_ok && q_full && !pop)
        err_overflow <= 1'b1;
    end
  end

  // ---------------- error queue ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (q_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_cnt <= q_cnt + CNT_W'(q_wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (q_wr) mem[wr_ptr] <= error_code;
  end

endmodule

// File: tb/tb_ble_session_controller.sv
// Self-checking bench for ble_session_controller: directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a queue-based behavioural model of the session rules.
module tb_ble_session_controller;

  localparam int ERR_CODE_W = 2;
  localparam int TX_DATA_W  = 8;
  localparam int DEPTH      = 4;
  localparam int MAXR       = 3;
  localparam int SLP_W      = 24;

  // model phase names
  localparam int M_IDLE = 0, M_PROG = 1, M_EACK = 2, M_SETUP = 3,
                 M_ADV = 4, M_CONN = 5, M_LOCK = 6;

  logic clk = 1'b0;
  logic rst;
  logic [SLP_W-1:0] slp_time_count;
  logic programming, direct_conn, setup_done, fail, connect, disconnect, time_out;
  logic error_pulse, tx_full, tmr_done;
  logic [ERR_CODE_W-1:0] error_code;
  logic tmr_enable, tmr_clear, en_cmd_mem_wr, setting_up, mux_tx_setup, mux_transceiver;
  logic [SLP_W-1:0] tmr_count;
  logic [1:0] mux_rx_setup;
  logic tx_valid, locked_out, err_overflow;
  logic [TX_DATA_W-1:0] tx_data;
  logic [3:0] retry_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  ble_session_controller #(
    .ERR_CODE_W(ERR_CODE_W), .TX_DATA_W(TX_DATA_W), .ERR_FIFO_DEPTH(DEPTH),
    .MAX_RETRIES(MAXR), .SLP_W(SLP_W)
  ) dut (
    .clk(clk), .rst(rst), .slp_time_count(slp_time_count),
    .programming(programming), .direct_conn(direct_conn),
    .setup_done(setup_done), .fail(fail), .connect(connect),
    .disconnect(disconnect), .time_out(time_out),
    .error_pulse(error_pulse), .error_code(error_code),
    .tx_full(tx_full), .tmr_done(tmr_done),
    .tmr_enable(tmr_enable), .tmr_clear(tmr_clear), .tmr_count(tmr_count),
    .en_cmd_mem_wr(en_cmd_mem_wr), .setting_up(setting_up),
    .mux_tx_setup(mux_tx_setup), .mux_transceiver(mux_transceiver),
    .mux_rx_setup(mux_rx_setup), .tx_valid(tx_valid), .tx_data(tx_data),
    .retry_cnt(retry_cnt), .locked_out(locked_out), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // ---------------- behavioural model ----------------
  int               ph;
  int               q[$];
  int               m_retry;
  bit               m_ovf;
  bit               m_clr;
  logic [SLP_W-1:0] m_tmr;
  int               nph, nretry, qn;
  bit               m_pop, m_push;

`ifdef BLE_SESSION_BACKOFF_EN
  function automatic logic [SLP_W-1:0] sleep_val(logic [SLP_W-1:0] b, int r);
    longint v, lim;
    v   = longint'(b) << r;
    lim = (longint'(1) << SLP_W) - 1;
    if (v > lim) return '1;
    return SLP_W'(v);
  endfunction
`endif

  // an attempt failed: either give up into LOCK or go back to sleep one retry up
  task automatic retry_path();
    if (m_retry + 1 == MAXR) nph = M_LOCK;
    else begin
      nph    = M_IDLE;
      nretry = m_retry + 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = M_IDLE; q.delete(); m_retry = 0; m_ovf = 0; m_clr = 1; m_tmr = '0;
    end else begin
      qn     = q.size();
      m_pop  = (ph == M_EACK) && qn > 0 && !tx_full;
      m_push = error_pulse && (ph == M_PROG || ph == M_EACK);
      nph    = ph;
      nretry = m_retry;
      case (ph)
        M_IDLE:  if (programming) nph = M_PROG; else if (direct_conn) nph = M_CONN;
                 else if (tmr_done) nph = M_SETUP;
        M_PROG:  if (qn > 0) nph = M_EACK; else if (!programming) nph = M_IDLE;
        M_EACK:  if (qn == 0) nph = M_PROG;
        M_SETUP: if (fail) retry_path(); else if (setup_done) nph = M_ADV;
        M_ADV:   if (connect) begin nph = M_CONN; nretry = 0; end
                 else if (time_out) retry_path();
        M_CONN:  if (disconnect) begin nph = M_IDLE; nretry = 0; end
        M_LOCK:  if (programming) begin nph = M_PROG; nretry = 0; end
        default: nph = M_IDLE;
      endcase
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (qn == DEPTH && !m_pop) m_ovf = 1;
        else q.push_back(int'(error_code));
      end
      if (nph == M_PROG && (ph == M_IDLE || ph == M_LOCK)) m_ovf = 0;
      m_clr = (nph == M_IDLE) && (ph != M_IDLE);
`ifdef BLE_SESSION_BACKOFF_EN
      if (m_clr) m_tmr = sleep_val(slp_time_count, m_retry);
`else
      if (m_clr) m_tmr = slp_time_count;
`endif
      m_retry = nretry;
      ph      = nph;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0] exp_v, act_v;
  bit          e_txv;
  always @(negedge clk) begin
    e_txv = (ph == M_EACK) && q.size() > 0 && !tx_full;
    exp_v = {17'd0,
             ph == M_IDLE, m_clr && !rst, m_tmr,
             ph == M_PROG, ph == M_SETUP,
             (ph == M_PROG || ph == M_EACK), ph == M_CONN,
             (ph == M_PROG || ph == M_EACK) ? 2'b01 : (ph == M_ADV ? 2'b10 : 2'b00),
             e_txv, e_txv ? TX_DATA_W'(q[0]) : TX_DATA_W'(0),
             4'(m_retry), ph == M_LOCK, m_ovf};
    act_v = {17'd0,
             tmr_enable, tmr_clear, tmr_count,
             en_cmd_mem_wr, setting_up, mux_tx_setup, mux_transceiver,
             mux_rx_setup, tx_valid, tx_data, retry_cnt, locked_out, err_overflow};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL outputs cycle=%0d got %h expected %h", cycle, act_v, exp_v);
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_pulses();
    setup_done = 0; fail = 0; connect = 0; disconnect = 0; time_out = 0;
    error_pulse = 0; tmr_done = 0;
  endtask

  int got[8];
  int n;
  int codes[5];
  bit seen;

  initial begin
    rst = 1; slp_time_count = 50; programming = 0; direct_conn = 0;
    tx_full = 0; error_code = 0;
    clear_pulses();

    // reset
    repeat (2) cyc();
    chk("rst_tmr_enable", tmr_enable, 1);
    chk("rst_tmr_clear", tmr_clear, 0);
    chk("rst_tmr_count", tmr_count, 0);
    chk("rst_retry", retry_cnt, 0);
    rst = 0;
    #3;
    chk("post_rst_clear", tmr_clear, 1);
    cyc();
    chk("clear_single", tmr_clear, 0);

    // sleep expiry -> setup
    tmr_done = 1; cyc(); tmr_done = 0;
    chk("setup_setting_up", setting_up, 1);
    chk("setup_tmr_enable", tmr_enable, 0);

    // setup_done -> advertise -> connect -> disconnect
    setup_done = 1; cyc(); setup_done = 0;
    chk("adv_rx", mux_rx_setup, 2);
    connect = 1; cyc(); connect = 0;
    chk("conn_transceiver", mux_transceiver, 1);
    chk("conn_retry", retry_cnt, 0);
    disconnect = 1; cyc(); disconnect = 0;
    chk("disc_idle", tmr_enable, 1);
    chk("disc_clear", tmr_clear, 1);
    chk("disc_tmr_count", tmr_count, 50);

    // programming with three queued errors held off by tx_full
    programming = 1; cyc();
    chk("prog_cmd_wr", en_cmd_mem_wr, 1);
    tx_full = 1;
    for (int i = 1; i <= 3; i++) begin
      error_code = ERR_CODE_W'(i); error_pulse = 1; cyc(); error_pulse = 0;
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("held_tx_valid", tx_valid, 0);
    end
    tx_full = 0;
    n = 0;
    for (int i = 0; i < 12 && n < 3; i++) begin
      #1;
      if (tx_valid) begin got[n] = int'(tx_data); n++; end
      cyc();
    end
    chk("drain3_count", n, 3);
    chk("drain3_d0", got[0], 1);
    chk("drain3_d1", got[1], 2);
    chk("drain3_d2", got[2], 3);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin cyc(); seen = en_cmd_mem_wr; end
    chk("back_to_prog", seen, 1);

    // five back-to-back errors into a depth-4 queue
    codes = '{3, 1, 2, 0, 1};
    tx_full = 1;
    for (int i = 0; i < 5; i++) begin
      error_code = ERR_CODE_W'(codes[i]); error_pulse = 1; cyc(); error_pulse = 0;
    end
    chk("ovf_set", err_overflow, 1);
    tx_full = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (tx_valid && n < 8) begin got[n] = int'(tx_data); n++; end
      cyc();
    end
    chk("drain4_count", n, 4);
    for (int i = 0; i < 4; i++) chk("drain4_data", got[i], codes[i]);
    programming = 0; cyc();
    chk("prog_exit_idle", tmr_enable, 1);
    chk("ovf_sticky", err_overflow, 1);
    programming = 1; cyc();
    chk("ovf_cleared", err_overflow, 0);
    programming = 0; cyc();

    // three failed attempts -> lockout
    slp_time_count = 10;
    tmr_done = 1; cyc(); tmr_done = 0;
    fail = 1; setup_done = 1; cyc(); clear_pulses();
    chk("fail1_retry", retry_cnt, 1);
    chk("fail1_tmr", tmr_count, 10);
    tmr_done = 1; cyc(); tmr_done = 0;
    fail = 1; cyc(); fail = 0;
    chk("fail2_retry", retry_cnt, 2);
`ifdef BLE_SESSION_BACKOFF_EN
    chk("fail2_tmr", tmr_count, 20);
`else
    chk("fail2_tmr", tmr_count, 10);
`endif
    tmr_done = 1; cyc(); tmr_done = 0;
    fail = 1; cyc(); fail = 0;
    chk("lockout", locked_out, 1);
    chk("lockout_retry", retry_cnt, 2);
    programming = 1; cyc();
    chk("unlock_retry", retry_cnt, 0);
    chk("unlock_prog", en_cmd_mem_wr, 1);
    programming = 0; cyc();

    // programming beats direct_conn; direct_conn alone connects
    direct_conn = 1; programming = 1; cyc();
    chk("prio_prog", en_cmd_mem_wr, 1);
    programming = 0; cyc();
    chk("prio_idle", tmr_enable, 1);
    cyc();
    chk("direct_conn", mux_transceiver, 1);
    direct_conn = 0; disconnect = 1; cyc(); disconnect = 0;

    // connect wins over time_out
    tmr_done = 1; cyc(); tmr_done = 0;
    setup_done = 1; cyc(); setup_done = 0;
    connect = 1; time_out = 1; cyc(); clear_pulses();
    chk("connect_wins", mux_transceiver, 1);
    disconnect = 1; cyc(); disconnect = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(399) == 0);
      if ($urandom_range(15) == 0) programming = ~programming;
      direct_conn = ($urandom_range(23) == 0);
      tmr_done    = ($urandom_range(5) == 0);
      setup_done  = ($urandom_range(3) == 0);
      fail        = ($urandom_range(4) == 0);
      connect     = ($urandom_range(5) == 0);
      disconnect  = ($urandom_range(7) == 0);
      time_out    = ($urandom_range(5) == 0);
      error_pulse = ($urandom_range(1) == 0);
      error_code  = ERR_CODE_W'($urandom);
      tx_full     = ($urandom_range(2) != 0);
      if ($urandom_range(31) == 0)
        slp_time_count = ($urandom_range(3) == 0) ? SLP_W'($urandom) : SLP_W'($urandom_range(200));
      cyc();
    end
    rst = 0;
    clear_pulses();
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
